flag_branch_ctrl: RTL and testbench

FLAG_BRANCH_CTRL -- requirements
Module: flag_branch_ctrl

---
 rtl/flag_pkg.sv | 38 +++
 rtl/flag_branch_ctrl_nor64.sv | 7 +
 rtl/flag_branch_ctrl.sv | 102 ++++++++++
 tb/tb_flag_branch_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - shared types and condition evaluation for flag_branch_ctrl
package flag_pkg;

    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    typedef enum logic [1:0] {NONE, ALU, CBZ, BCOND} req_kind_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic cond_eval(input cond_e cond, input flags_t f);
        cond_eval = 1'b1;
        case (cond)
            EQ: cond_eval = f.z;
            NE: cond_eval = ~f.z;
            CS: cond_eval = f.c;
            CC: cond_eval = ~f.c;
            MI: cond_eval = f.n;
            PL: cond_eval = ~f.n;
            VS: cond_eval = f.v;
            VC: cond_eval = ~f.v;
            HI: cond_eval = f.c & ~f.z;
            LS: cond_eval = ~(f.c & ~f.z);
            GE: cond_eval = (f.n == f.v);
            LT: cond_eval = (f.n != f.v);
            GT: cond_eval = ~f.z & (f.n == f.v);
            LE: cond_eval = ~(~f.z & (f.n == f.v));
            default: cond_eval = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/flag_branch_ctrl_nor64.sv
// rtl/flag_branch_ctrl_nor64.sv - 64-bit NOR-reduction zero detector
module NOR_64to1 (
    input  logic [63:0] data,
    output logic        nor_out
);
    assign nor_out = ~|data;
endmodule

// File: rtl/flag_branch_ctrl.sv
// rtl/flag_branch_ctrl.sv - NZCV flag register and CBZ/B.cond branch resolver
// One stage register feeds a single shared zero detector for both ALU and CBZ.
module flag_branch_ctrl
    import flag_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic        set_flags,
    input  logic [63:0] alu_result,
    input  logic        alu_neg,
    input  logic        alu_carry,
    input  logic        alu_ovf,
    input  logic        cbz_req,
    input  logic        cbz_nz,
    input  logic [63:0] cbz_val,
    output logic        cbz_rdy,
    input  logic        bcond_req,
    input  logic [3:0]  cond,
    output logic        bcond_rdy,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v,
    output logic        br_valid,
    output logic        br_taken
);

    req_kind_e   stage_kind;
    logic [63:0] stage_op;
    logic        stage_nz;
    cond_e       stage_cond;
    logic        stage_n;
    logic        stage_c;
    logic        stage_v;
    flags_t      flags_q;
    logic        zero;
    logic        alu_take;

    NOR_64to1 u_zero (
        .data    (stage_op),
        .nor_out (zero)
    );

    assign alu_take  = alu_valid & set_flags;
    assign cbz_rdy   = cbz_req & ~alu_valid;
    assign bcond_rdy = bcond_req & ~cbz_req & ~alu_take;

    assign flag_n = flags_q.n;
    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_kind <= NONE;
            stage_op   <= '0;
            stage_nz   <= 1'b0;
            stage_cond <= EQ;
            stage_n    <= 1'b0;
            stage_c    <= 1'b0;
            stage_v    <= 1'b0;
            flags_q    <= '0;
            br_valid   <= 1'b0;
            br_taken   <= 1'b0;
        end else begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
            // B.cond reads flags_q here, which already holds any ALU update from the prior slot
            case (stage_kind)
                ALU: flags_q <= '{n: stage_n, z: zero, c: stage_c, v: stage_v};
                CBZ: begin
                    br_valid <= 1'b1;
                    br_taken <= zero ^ stage_nz;
                end
                BCOND: begin
                    br_valid <= 1'b1;
                    br_taken <= cond_eval(stage_cond, flags_q);
                end
                default: ;
            endcase

            if (alu_take) begin
                stage_kind <= ALU;
                stage_op   <= alu_result;
                stage_n    <= alu_neg;
                stage_c    <= alu_carry;
                stage_v    <= alu_ovf;
            end else if (cbz_rdy) begin
                stage_kind <= CBZ;
                stage_op   <= cbz_val;
                stage_nz   <= cbz_nz;
            end else if (bcond_rdy) begin
                stage_kind <= BCOND;
                stage_cond <= cond_e'(cond);
            end else begin
                stage_kind <= NONE;
            end
        end
    end

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// tb/tb_flag_branch_ctrl.sv - scoreboard bench for flag_branch_ctrl
module tb_flag_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, set_flags = 1'b0;
    logic [63:0] alu_result = '0;
    logic        alu_neg = 1'b0, alu_carry = 1'b0, alu_ovf = 1'b0;
    logic        cbz_req = 1'b0, cbz_nz = 1'b0;
    logic [63:0] cbz_val = '0;
    logic        cbz_rdy;
    logic        bcond_req = 1'b0;
    logic [3:0]  cond = '0;
    logic        bcond_rdy;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        br_valid, br_taken;

    flag_branch_ctrl dut (
        .clk(clk), .reset(reset), .alu_valid(alu_valid), .set_flags(set_flags),
        .alu_result(alu_result), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .cbz_req(cbz_req), .cbz_nz(cbz_nz), .cbz_val(cbz_val), .cbz_rdy(cbz_rdy),
        .bcond_req(bcond_req), .cond(cond), .bcond_rdy(bcond_rdy),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .br_valid(br_valid), .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit taken;
    } exp_t;

    exp_t     sb[$];
    int       vectors = 0;
    int       errs = 0;
    bit       mon_en = 1'b0;
    bit       chk_flags = 1'b0;
    bit [3:0] mflags = '0;   // {n,z,c,v}
    bit       pend_v = 1'b0;
    bit [3:0] pend_f = '0;

    // pairs of conditions share a base test; odd codes invert it, 14/15 always taken
    function automatic bit ref_cond(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c >> 1)
            0: base = z;
            1: base = cy;
            2: base = n;
            3: base = v;
            4: base = cy && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit av, input bit sf, input logic [63:0] res,
                        input bit an, input bit ac, input bit ao,
                        input bit cr, input bit cnz, input logic [63:0] cv,
                        input bit br, input logic [3:0] cd,
                        output bit c_acc, output bit b_acc);
        bit [3:0] fa;
        @(negedge clk);
        reset = rst; alu_valid = av; set_flags = sf; alu_result = res;
        alu_neg = an; alu_carry = ac; alu_ovf = ao;
        cbz_req = cr; cbz_nz = cnz; cbz_val = cv; bcond_req = br; cond = cd;
        #1;
        c_acc = cr && !av;
        b_acc = br && !cr && !(av && sf);
        check("cbz_rdy", cbz_rdy, c_acc);
        check("bcond_rdy", bcond_rdy, b_acc);
        if (chk_flags) check("flags", {flag_n, flag_z, flag_c, flag_v}, mflags);
        fa = pend_v ? pend_f : mflags;
        if (rst) begin
            sb.delete();
            mflags = '0;
            pend_v = 1'b0;
        end else begin
            if (c_acc) sb.push_back('{cyc + 2, (cv == 64'd0) ^ cnz});
            else if (b_acc) sb.push_back('{cyc + 2, ref_cond(cd, fa)});
            mflags = fa;
            pend_v = av && sf;
            pend_f = {an, res == 64'd0, ac, ao};
        end
    endtask

    task automatic idle(input bit rst);
        bit a, b;
        step(rst, 0, 0, 64'd0, 0, 0, 0, 0, 0, 64'd0, 0, 4'd0, a, b);
    endtask

    // monitor: every cycle, a branch pulse must match the head of the scoreboard exactly
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (br_valid === 1'b1) begin
                    if (sb.size() == 0 || sb[0].due != cyc) begin
                        check("spurious_br_valid", 1, 0);
                    end else begin
                        check("br_taken", br_taken, sb[0].taken);
                        void'(sb.pop_front());
                    end
                end else begin
                    check("br_taken_idle", br_taken, 0);
                    if (sb.size() != 0 && sb[0].due == cyc) begin
                        check("missing_br_valid", br_valid, 1);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit a, b;
        bit hold_c, hold_b, h_nz;
        logic [63:0] h_val;
        logic [3:0] h_cd;

        idle(1); idle(1);
        chk_flags = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) idle(0);

        // zero result with carry -> Z=1 C=1, then B.EQ taken
        step(0, 1, 1, 64'd0, 0, 1, 0, 0, 0, 64'd0, 0, 4'd0, a, b);
        step(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 64'd0, 1, 4'd0, a, b);
        idle(0);

        // ALU blocks CBZ, CBZ retries next cycle
        step(0, 1, 0, 64'd5, 0, 0, 0, 1, 0, 64'd0, 0, 4'd0, a, b);
        step(0, 0, 0, 64'd0, 0, 0, 0, 1, 0, 64'd0, 0, 4'd0, a, b);

        // CBNZ beats B.cond, B.cond follows
        step(0, 0, 0, 64'd0, 0, 0, 0, 1, 1, 64'h8000_0000_0000_0000, 1, 4'd1, a, b);
        step(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 64'd0, 1, 4'd1, a, b);

        // N=1 V=0 with a blocked B.cond, then GE and LT back to back
        step(0, 1, 1, 64'd7, 1, 0, 0, 0, 0, 64'd0, 1, 4'd10, a, b);
        step(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 64'd0, 1, 4'd10, a, b);
        step(0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 64'd0, 1, 4'd11, a, b);
        idle(0);

        // CBZ accepted, then reset kills it
        step(0, 0, 0, 64'd0, 0, 0, 0, 1, 0, 64'd0, 0, 4'd0, a, b);
        idle(1);
        for (int i = 0; i < 4; i++) idle(0);

        hold_c = 0; hold_b = 0; h_nz = 0; h_val = '0; h_cd = '0;
        for (int i = 0; i < 400; i++) begin
            bit av, sf, an, ac, ao, rst;
            logic [63:0] res;
            av = ($urandom_range(0, 2) == 0);
            sf = $urandom_range(0, 1);
            res = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            an = $urandom_range(0, 1); ac = $urandom_range(0, 1); ao = $urandom_range(0, 1);
            rst = ($urandom_range(0, 60) == 0);
            if (!hold_c && $urandom_range(0, 2) == 0) begin
                hold_c = 1; h_nz = $urandom_range(0, 1);
                h_val = ($urandom_range(0, 1) == 0) ? 64'd0 : (64'd1 << $urandom_range(0, 63));
            end
            if (!hold_b && $urandom_range(0, 1) == 0) begin
                hold_b = 1; h_cd = 4'($urandom_range(0, 15));
            end
            step(rst, av, sf, res, an, ac, ao, hold_c, h_nz, h_val, hold_b, h_cd, a, b);
            if (a) hold_c = 0;
            if (b) hold_b = 0;
        end

        for (int i = 0; i < 4; i++) idle(0);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
